// File: rtl/riscv_wb.sv
// Write-back stage: a 2-entry result buffer feeding a registered regfile write port.
// Define RISCV_WB_LOADEXT_EN to extract and extend load data by funct3 and byte offset.
module riscv_wb #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_MEM_valid,
    output logic            o_MEM_ready,
    input  logic            i_MEM_reg_wr_en,
    input  logic [1:0]      i_MEM_src_rd,
    input  logic [2:0]      i_MEM_funct3,
    input  logic [XLEN-1:0] i_MEM_alu_result,
    input  logic [XLEN-1:0] i_MEM_rdata,
    input  logic [XLEN-1:0] i_MEM_pc4,
    input  logic [XLEN-1:0] i_MEM_imm,
    input  logic [4:0]      i_MEM_rd,
    input  logic            i_WB_stall,
    output logic            o_WB_reg_wr_en,
    output logic [4:0]      o_WB_rd,
    output logic [XLEN-1:0] o_WB_rd_data,
    output logic            o_WB_busy,
    output logic [31:0]     o_WB_retire_cnt
);
    localparam int EW = XLEN + 6;

    logic [EW-1:0]   fifo_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      count;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] sel_data;
    logic [EW-1:0]   head;

    // Handshake: a result transfers on a rising edge where i_MEM_valid and
    // o_MEM_ready are both 1; ready depends only on the registered count.
    assign o_MEM_ready = (count < 2'd2);
    assign o_WB_busy   = (count != 2'd0);
    assign push        = i_MEM_valid & o_MEM_ready;
    assign pop         = (count != 2'd0) & ~i_WB_stall;
    assign head        = fifo_mem[rd_ptr];

`ifdef RISCV_WB_LOADEXT_EN
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = i_MEM_rdata[7:0];
        case (i_MEM_alu_result[1:0])
            2'd0: ld_byte = i_MEM_rdata[7:0];
            2'd1: ld_byte = i_MEM_rdata[15:8];
            2'd2: ld_byte = i_MEM_rdata[23:16];
            2'd3: ld_byte = i_MEM_rdata[31:24];
            default: ld_byte = i_MEM_rdata[7:0];
        endcase
        ld_half = i_MEM_alu_result[1] ? i_MEM_rdata[31:16] : i_MEM_rdata[15:0];
        case (i_MEM_funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = i_MEM_rdata;
        endcase
    end
`else
    logic unused_funct3;
    assign unused_funct3 = ^i_MEM_funct3;
    assign load_data     = i_MEM_rdata;
`endif

    always_comb begin
        sel_data = i_MEM_alu_result;
        case (i_MEM_src_rd)
            2'b00:   sel_data = i_MEM_alu_result;
            2'b01:   sel_data = load_data;
            2'b10:   sel_data = i_MEM_pc4;
            2'b11:   sel_data = i_MEM_imm;
            default: sel_data = i_MEM_alu_result;
        endcase
    end

    // Storage needs no reset: the pointers and count decide what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {i_MEM_reg_wr_en, i_MEM_rd, sel_data};
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // x0 entries still retire, they just never assert the write enable.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_WB_reg_wr_en  <= 1'b0;
            o_WB_rd         <= 5'd0;
            o_WB_rd_data    <= '0;
            o_WB_retire_cnt <= 32'd0;
        end else if (pop) begin
            o_WB_reg_wr_en  <= head[EW-1] & (head[EW-2:XLEN] != 5'd0);
            o_WB_rd         <= head[EW-2:XLEN];
            o_WB_rd_data    <= head[XLEN-1:0];
            o_WB_retire_cnt <= o_WB_retire_cnt + 32'd1;
        end else begin
            o_WB_reg_wr_en  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_riscv_wb.sv
// Bench for riscv_wb: random and directed results through a queue-based model,
// checked by an independent monitor on the regfile write port.
module tb_riscv_wb;
    localparam int XLEN = 32;
    localparam int EW   = XLEN + 6;

    typedef struct packed {
        logic            we;
        logic [1:0]      src;
        logic [2:0]      f3;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
    } txn_t;

    logic            i_clk;
    logic            i_rstn;
    logic            i_MEM_valid;
    logic            o_MEM_ready;
    logic            i_MEM_reg_wr_en;
    logic [1:0]      i_MEM_src_rd;
    logic [2:0]      i_MEM_funct3;
    logic [XLEN-1:0] i_MEM_alu_result;
    logic [XLEN-1:0] i_MEM_rdata;
    logic [XLEN-1:0] i_MEM_pc4;
    logic [XLEN-1:0] i_MEM_imm;
    logic [4:0]      i_MEM_rd;
    logic            i_WB_stall;
    logic            o_WB_reg_wr_en;
    logic [4:0]      o_WB_rd;
    logic [XLEN-1:0] o_WB_rd_data;
    logic            o_WB_busy;
    logic [31:0]     o_WB_retire_cnt;

    riscv_wb #(.XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_MEM_valid(i_MEM_valid), .o_MEM_ready(o_MEM_ready),
        .i_MEM_reg_wr_en(i_MEM_reg_wr_en), .i_MEM_src_rd(i_MEM_src_rd),
        .i_MEM_funct3(i_MEM_funct3), .i_MEM_alu_result(i_MEM_alu_result),
        .i_MEM_rdata(i_MEM_rdata), .i_MEM_pc4(i_MEM_pc4), .i_MEM_imm(i_MEM_imm),
        .i_MEM_rd(i_MEM_rd), .i_WB_stall(i_WB_stall),
        .o_WB_reg_wr_en(o_WB_reg_wr_en), .o_WB_rd(o_WB_rd),
        .o_WB_rd_data(o_WB_rd_data), .o_WB_busy(o_WB_busy),
        .o_WB_retire_cnt(o_WB_retire_cnt)
    );

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // scoreboard state
    logic [EW-1:0]   exp_q[$];
    logic            exp_pop = 1'b0;
    logic [31:0]     model_retire = 32'd0;
    logic [4:0]      prev_rd = 5'd0;
    logic [XLEN-1:0] prev_data = '0;
    logic            stall_force = 1'b0;
    logic            rand_stall = 1'b0;
    int              n_cmp = 0;
    int              n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: rd data chosen from the source rule, loads sliced arithmetically.
    function automatic logic [XLEN-1:0] ref_data(input txn_t t);
        logic [XLEN-1:0] sh;
        case (t.src)
            2'b00: return t.alu;
            2'b10: return t.pc4;
            2'b11: return t.imm;
            default: ;
        endcase
`ifdef RISCV_WB_LOADEXT_EN
        case (t.f3)
            3'b000: begin
                sh = t.rdata >> (8 * t.alu[1:0]);
                return {{(XLEN-8){sh[7]}}, sh[7:0]};
            end
            3'b100: begin
                sh = t.rdata >> (8 * t.alu[1:0]);
                return {{(XLEN-8){1'b0}}, sh[7:0]};
            end
            3'b001: begin
                sh = t.rdata >> (16 * t.alu[1]);
                return {{(XLEN-16){sh[15]}}, sh[15:0]};
            end
            3'b101: begin
                sh = t.rdata >> (16 * t.alu[1]);
                return {{(XLEN-16){1'b0}}, sh[15:0]};
            end
            default: return t.rdata;
        endcase
`else
        return t.rdata;
`endif
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = ($urandom_range(0, 3) != 0);
        t.src   = 2'($urandom_range(0, 3));
        t.f3    = 3'($urandom_range(0, 7));
        t.alu   = $urandom;
        t.rdata = $urandom;
        t.pc4   = $urandom;
        t.imm   = $urandom;
        t.rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        return t;
    endfunction

    // driver: one clock cycle of stimulus; predicts accept and pop for the coming edge
    task automatic cycle(input logic rst, input logic v, input txn_t t,
                         input logic use_exp, input logic [XLEN-1:0] exp_d,
                         output logic acc);
        @(negedge i_clk);
        #2;
        i_rstn           = rst;
        i_MEM_valid      = v;
        i_MEM_reg_wr_en  = t.we;
        i_MEM_src_rd     = t.src;
        i_MEM_funct3     = t.f3;
        i_MEM_alu_result = t.alu;
        i_MEM_rdata      = t.rdata;
        i_MEM_pc4        = t.pc4;
        i_MEM_imm        = t.imm;
        i_MEM_rd         = t.rd;
        i_WB_stall       = stall_force | (rand_stall && ($urandom_range(0, 3) == 0));
        if (!rst) begin
            exp_q.delete();
            model_retire = 32'd0;
        end
        #1;
        exp_pop = rst && (exp_q.size() != 0) && !i_WB_stall;
        acc     = rst && v && (exp_q.size() < 2);
        if (acc) exp_q.push_back({t.we && (t.rd != 5'd0), t.rd, use_exp ? exp_d : ref_data(t)});
    endtask

    task automatic idle(input int n);
        logic a;
        txn_t z;
        z = '0;
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, z, 1'b0, '0, a);
    endtask

    task automatic rst_cycles(input int n, input logic v);
        logic a;
        txn_t t;
        for (int i = 0; i < n; i++) begin
            t = rand_txn();
            cycle(1'b0, v, t, 1'b0, '0, a);
        end
    endtask

    task automatic send_x(input txn_t t, input logic use_exp, input logic [XLEN-1:0] exp_d,
                          output int used);
        logic a;
        used = 0;
        a = 1'b0;
        while (!a && used < 50) begin
            cycle(1'b1, 1'b1, t, use_exp, exp_d, a);
            used++;
        end
        if (!a) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: not accepted after %0d cycles", used);
        end
    endtask

    task automatic send(input txn_t t);
        int u;
        send_x(t, 1'b0, '0, u);
    endtask

    // monitor: pops the expected queue whenever the model says the DUT retires a result
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            chk("rst_wr_en", 64'(o_WB_reg_wr_en), 64'd0);
            chk("rst_retire", 64'(o_WB_retire_cnt), 64'd0);
            chk("rst_ready", 64'(o_MEM_ready), 64'd1);
            prev_rd   = 5'd0;
            prev_data = '0;
        end else begin
            if (exp_pop) begin
                if (exp_q.size() == 0) begin
                    chk("pop_underflow", 64'd1, 64'd0);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    chk("wb_wr_en", 64'(o_WB_reg_wr_en), 64'(e[EW-1]));
                    chk("wb_rd", 64'(o_WB_rd), 64'(e[EW-2:XLEN]));
                    chk("wb_data", 64'(o_WB_rd_data), 64'(e[XLEN-1:0]));
                    prev_rd   = e[EW-2:XLEN];
                    prev_data = e[XLEN-1:0];
                    model_retire = model_retire + 32'd1;
                end
            end else begin
                chk("idle_wr_en", 64'(o_WB_reg_wr_en), 64'd0);
                chk("hold_rd", 64'(o_WB_rd), 64'(prev_rd));
                chk("hold_data", 64'(o_WB_rd_data), 64'(prev_data));
            end
            chk("retire_cnt", 64'(o_WB_retire_cnt), 64'(model_retire));
            chk("busy", 64'(o_WB_busy), 64'(exp_q.size() != 0));
            chk("ready", 64'(o_MEM_ready), 64'(exp_q.size() < 2));
        end
    end

    initial begin
        txn_t t;
        int   u;
        int   total;
        logic a;
        logic [31:0] base;

        i_rstn = 1'b0; i_MEM_valid = 1'b0; i_MEM_reg_wr_en = 1'b0; i_MEM_src_rd = 2'd0;
        i_MEM_funct3 = 3'd0; i_MEM_alu_result = '0; i_MEM_rdata = '0; i_MEM_pc4 = '0;
        i_MEM_imm = '0; i_MEM_rd = 5'd0; i_WB_stall = 1'b0;

        rst_cycles(3, 1'b1);
        idle(2);

        // single ALU result to x5
        t = '0; t.we = 1'b1; t.src = 2'b00; t.alu = 32'h1234; t.rd = 5'd5;
        send(t);
        idle(3);
        chk("first_retire", 64'(o_WB_retire_cnt), 64'd1);

        // signed / unsigned byte load at offset 1
        t = '0; t.we = 1'b1; t.src = 2'b01; t.f3 = 3'b000; t.rdata = 32'h0000_8000;
        t.alu = 32'h1; t.rd = 5'd7;
`ifdef RISCV_WB_LOADEXT_EN
        send_x(t, 1'b1, 32'hFFFF_FF80, u);
        t.f3 = 3'b100;
        send_x(t, 1'b1, 32'h0000_0080, u);
`else
        send_x(t, 1'b1, 32'h0000_8000, u);
        t.f3 = 3'b100;
        send_x(t, 1'b1, 32'h0000_8000, u);
`endif
        idle(3);

        // stall fills the buffer, third offer is held back
        stall_force = 1'b1;
        t = rand_txn(); send(t);
        t = rand_txn(); send(t);
        t = rand_txn();
        cycle(1'b1, 1'b1, t, 1'b0, '0, a);
        chk("full_no_accept", 64'(a), 64'd0);
        chk("full_ready", 64'(o_MEM_ready), 64'd0);
        chk("full_busy", 64'(o_WB_busy), 64'd1);
        cycle(1'b1, 1'b1, t, 1'b0, '0, a);
        chk("full_no_accept2", 64'(a), 64'd0);
        stall_force = 1'b0;
        send(t);
        idle(4);

        // back-to-back stream, stall low: one accept per cycle
        base = model_retire;
        total = 0;
        for (int i = 0; i < 10; i++) begin
            t = rand_txn();
            send_x(t, 1'b0, '0, u);
            total += u;
        end
        chk("stream_cycles", 64'(total), 64'd10);
        idle(2);
        chk("stream_retire", 64'(o_WB_retire_cnt), 64'(base + 32'd10));

        // x0 destination with write enable set
        base = model_retire;
        t = rand_txn(); t.we = 1'b1; t.rd = 5'd0;
        send(t);
        idle(3);
        chk("x0_retire", 64'(o_WB_retire_cnt), 64'(base + 32'd1));

        // reset with two buffered entries
        stall_force = 1'b1;
        t = rand_txn(); t.we = 1'b1; t.rd = 5'd9; send(t);
        t = rand_txn(); t.we = 1'b1; t.rd = 5'd10; send(t);
        stall_force = 1'b0;
        rst_cycles(1, 1'b1);
        chk("rst_now_wr_en", 64'(o_WB_reg_wr_en), 64'd0);
        chk("rst_now_rd", 64'(o_WB_rd), 64'd0);
        chk("rst_now_data", 64'(o_WB_rd_data), 64'd0);
        chk("rst_now_busy", 64'(o_WB_busy), 64'd0);
        chk("rst_now_ready", 64'(o_MEM_ready), 64'd1);
        rst_cycles(2, 1'b1);
        idle(4);
        chk("post_rst_retire", 64'(o_WB_retire_cnt), 64'd0);

        // random traffic with random stalls and gaps
        rand_stall = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) idle(1);
            t = rand_txn();
            send(t);
        end
        rand_stall = 1'b0;
        idle(5);
        chk("drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_wb.md
RISCV_WB -- requirements
Module: riscv_wb

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (matches `XLEN).
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_MEM_valid  input  1  upstream result valid.
REQ-005 SHALL have port o_MEM_ready  output  1  block can accept a result this cycle.
REQ-006 SHALL have port i_MEM_reg_wr_en  input  1  instruction writes rd.
REQ-007 SHALL have port i_MEM_src_rd  input  2  rd source: 00 ALU, 01 load, 10 pc4, 11 imm.
REQ-008 SHALL have port i_MEM_funct3  input  3  load width/sign select.
REQ-009 SHALL have ports i_MEM_alu_result, i_MEM_rdata, i_MEM_pc4, i_MEM_imm  input  XLEN each  candidate rd data; alu_result[1:0] is load byte offset.
REQ-010 SHALL have port i_MEM_rd  input  5  destination register.
REQ-011 SHALL have port i_WB_stall  input  1  regfile write port unavailable this cycle.
REQ-012 SHALL have ports o_WB_reg_wr_en 1, o_WB_rd 5, o_WB_rd_data XLEN  output  registered regfile write port (drives ID-stage i_WB_*).
REQ-013 SHALL have port o_WB_busy  output  1  buffer non-empty.
REQ-014 SHALL have port o_WB_retire_cnt  output  32  count of results written out.

Function
REQ-015 Accept SHALL occur on a rising edge where i_MEM_valid=1 and o_MEM_ready=1; no other input sampled.
REQ-016 Accepted entry {wr_en, rd, data} SHALL be pushed into a 2-entry FIFO; data selected by i_MEM_src_rd at accept.
REQ-017 o_MEM_ready SHALL equal (count<2), from registered count only; no combinational path from i_WB_stall or i_MEM_valid.
REQ-018 On each edge with count>0 and i_WB_stall=0, head SHALL pop into output register: o_WB_reg_wr_en <= wr_en & (rd!=0), o_WB_rd <= rd, o_WB_rd_data <= data.
REQ-019 On edges with no pop, o_WB_reg_wr_en SHALL be 0; o_WB_rd and o_WB_rd_data SHALL hold.
REQ-020 Simultaneous push and pop SHALL both complete; count unchanged; FIFO order preserved.
REQ-021 Latency SHALL be 2 edges: accept at edge N, write visible after edge N+1 if unstalled; throughput 1/cycle.
REQ-022 i_WB_stall held SHALL fill FIFO; after 2 accepts o_MEM_ready=0 until a pop.
REQ-023 rd=0 entries SHALL pop normally (count, counter advance) with o_WB_reg_wr_en=0.
REQ-024 o_WB_retire_cnt SHALL increment by 1 on every pop, wrapping 0xFFFFFFFF -> 0.
REQ-025 o_WB_busy SHALL equal (count!=0).

Reset
REQ-026 i_rstn low SHALL immediately clear count, FIFO pointers, o_WB_reg_wr_en, o_WB_rd, o_WB_rd_data, o_WB_retire_cnt to 0.
REQ-027 Reset mid-operation SHALL discard buffered entries; no write issued for them.
REQ-028 While i_rstn low no accept SHALL occur; o_MEM_ready reads 1 (count=0).

Configuration
REQ-029 Macro RISCV_WB_LOADEXT_EN defined: load data (src_rd=01) SHALL be extracted/extended by funct3: 000 LB sign byte at offset, 001 LH sign half at offset[1], 100 LBU, 101 LHU zero-extend, 010 and others full word.
REQ-030 Macro undefined: load data SHALL pass i_MEM_rdata unmodified regardless of funct3/offset.

Verification
REQ-031 Accept {src 00, alu 0x1234, rd 5}, stall=0 -> after 2nd edge wr_en=1, rd=5, data=0x1234 for 1 cycle; retire_cnt=1.
REQ-032 LOADEXT_EN, src 01, funct3 000, rdata 0x0000_8000, offset 1 -> data 0xFFFF_FF80; funct3 100 -> 0x0000_0080; macro off -> 0x0000_8000.
REQ-033 Stall=1, offer 3 back-to-back -> 2 accepted, ready=0, busy=1; release stall -> writes in order on 2 consecutive cycles, 3rd then accepted.
REQ-034 Continuous valid, stall=0, 10 entries -> one write per cycle, no bubbles, retire_cnt=10.
REQ-035 rd=0 with wr_en=1 -> o_WB_reg_wr_en stays 0, retire_cnt increments.
REQ-036 Assert i_rstn low with 2 entries buffered -> outputs 0 immediately, no writes after release, ready=1.
